sync_fifo_ctl: RTL
==================

# sync_fifo_ctl

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for same-domain buffering. It adds an occupancy count output, programmable almost-full/almost-empty thresholds, and a synchronous flush. It also offers a selectable read mode: registered read or first-word-fall-through (FWFT). It sits between a producer and consumer sharing one clock, e.g. ahead of the UART/DMA datapaths.

## Interface
- DATA_W, 8: data width in bits, ≥1.
- DEPTH, 16: number of entries; power of 2, ≥2. A_W = clog2(DEPTH).
- FWFT, 0: 0 = registered read (1-cycle latency); 1 = head word continuously presented on rd_data_o.
- AF_THRESH, DEPTH-2: almost_full_o asserts when level ≥ AF_THRESH. Requires AE_THRESH < AF_THRESH ≤ DEPTH.
- AE_THRESH, 2: almost_empty_o asserts when level ≤ AE_THRESH. Requires 0 ≤ AE_THRESH.

- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of contents.
- wr_en_i  in  1  write request.
- wr_data_i  in  DATA_W  write data.
- full_o  out  1  level == DEPTH.
- almost_full_o  out  1  level ≥ AF_THRESH.
- overflow_o  out  1  1-cycle pulse: previous-cycle write was rejected.
- rd_en_i  in  1  read request (FWFT=1: pop/acknowledge of head).
- rd_data_o  out  DATA_W  read data.
- empty_o  out  1  level == 0.
- almost_empty_o  out  1  level ≤ AE_THRESH.
- underflow_o  out  1  1-cycle pulse: previous-cycle read was rejected.
- level_o  out  A_W+1  current occupancy, 0..DEPTH.

## Operation
- State: write pointer (A_W bits), read pointer (A_W bits), level register (A_W+1 bits), DEPTH×DATA_W storage, rd_data register, overflow/underflow registers. Pointers wrap modulo DEPTH naturally.
- rd_acc = rd_en_i & ~empty_o.
- wr_acc = wr_en_i & (~full_o | rd_acc). When full, a simultaneous accepted read makes room.
- Accepted write stores wr_data_i at the write pointer and increments the write pointer.
- Accepted read increments the read pointer. If FWFT=0, it also loads rd_data_o with the entry at the old read pointer.
- Level update: +1 for wr_acc only; −1 for rd_acc only; unchanged when both or neither.
- All flags are decoded from the level register: full_o, empty_o, almost_full_o, almost_empty_o, and level_o.
- overflow_o is registered as wr_en_i & ~wr_acc.
- underflow_o is registered as rd_en_i & empty_o. When empty, reads are rejected even if a write is accepted the same cycle.
- FWFT=0: rd_data_o holds its value between accepted reads.
- FWFT=1: rd_data_o = storage[read pointer] when ~empty_o, else all-zero. rd_data_o is combinational from the storage and pointer.
- flush_i = 1 has priority over wr_en_i/rd_en_i:
  - On the next edge, pointers and level are cleared to 0 and overflow_o/underflow_o are cleared to 0.
  - Storage is not cleared. The FWFT=0 rd_data_o register holds its value.
  - No overflow or underflow is flagged on a flush cycle.
- Reset (asynchronous, any time including mid-transfer): pointers, level, overflow_o, underflow_o and the rd_data register go to 0. Storage is not reset.
- Output values during reset: empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, level_o=0, rd_data_o=0.

## Timing
- Write accepted at edge N: level_o, empty_o and almost_* reflect it after edge N. An rd_en_i sampled at edge N+1 is accepted.
- FWFT=0 read: rd_acc at edge N puts data on rd_data_o after edge N (1-cycle latency).
- FWFT=1 read: the head word is valid on rd_data_o after the write edge. rd_acc at edge N advances to the next word after edge N.
- Back-to-back operation: one write and one read per cycle are sustained indefinitely at any level 1..DEPTH-1.
- overflow_o and underflow_o are high for exactly the one cycle after the offending request.
- A request held across multiple rejected cycles pulses overflow_o or underflow_o once per cycle.

## Test plan
- Reset then fill (FWFT=0, DATA_W=8, DEPTH=16): write 0x00..0x0F on 16 consecutive cycles.
  - Expected: level_o counts to 16; almost_full_o rises at level 14; full_o rises after the 16th write.
  - A 17th write gives overflow_o=1 for one cycle and level stays 16.
- Drain (FWFT=0): 16 consecutive reads.
  - Expected: rd_data_o = 0x00..0x0F, each one cycle after its rd_en_i.
  - almost_empty_o rises at level 2; empty_o rises at level 0.
  - A 17th read gives underflow_o=1 for one cycle and rd_data_o holds 0x0F.
- Wrap and simultaneous operation: with level 16, assert wr_en_i+rd_en_i for 40 cycles with incrementing data.
  - Expected: level stays 16, no overflow, read order strictly matches write order across pointer wrap.
- Empty with both requests: at level 0, assert wr_en_i(0xA5) and rd_en_i together.
  - Expected: write accepted, underflow_o=1, level_o=1.
  - The next read returns 0xA5.
- FWFT=1: write 0x11 then 0x22.
  - Expected: rd_data_o=0x11 the cycle after the first write.
  - rd_en_i gives 0x22 next; a second rd_en_i gives empty_o=1 and rd_data_o=0x00.
- Flush and async reset: at level 5, assert flush_i together with wr_en_i.
  - Expected: level_o=0, empty_o=1, no write accepted, no overflow.
  - Refill to 3, then pulse rst_ni low mid-cycle. Expected: all outputs at reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with occupancy count, programmable almost-full/
// almost-empty thresholds, synchronous flush and registered or FWFT read port.
module sync_fifo_ctl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int A_W      = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              overflow_o,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o,
  output logic              almost_empty_o,
  output logic              underflow_o,
  output logic [A_W:0]      level_o
);

  localparam int LVL_W = A_W + 1;
  localparam logic [A_W:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [A_W:0] AF_L    = LVL_W'(AF_THRESH);
  localparam logic [A_W:0] AE_L    = LVL_W'(AE_THRESH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [A_W-1:0]    wr_ptr_r;
  logic [A_W-1:0]    rd_ptr_r;
  logic [A_W:0]      level_r;
  logic [A_W:0]      level_nxt_s;
  logic              overflow_r;
  logic              underflow_r;
  logic              full_s;
  logic              empty_s;
  logic              rd_acc_s;
  logic              wr_acc_s;
  logic [DATA_W-1:0] rd_data_s;

  // Accept decisions and next occupancy; flush suppresses both requests.
  always_comb begin
    full_s      = (level_r == DEPTH_L);
    empty_s     = (level_r == {LVL_W{1'b0}});
    rd_acc_s    = ~flush_i & rd_en_i & ~empty_s;
    wr_acc_s    = ~flush_i & wr_en_i & (~full_s | rd_acc_s);
    level_nxt_s = level_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers, occupancy and the one-cycle rejection pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r    <= {A_W{1'b0}};
      rd_ptr_r    <= {A_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_r    <= {A_W{1'b0}};
      rd_ptr_r    <= {A_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + A_W'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + A_W'(1);
      end
      level_r     <= level_nxt_s;
      overflow_r  <= wr_en_i & ~wr_acc_s;
      underflow_r <= rd_en_i & empty_s;
    end
  end

  // Storage array; deliberately not reset or flushed.
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_data_i;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word presented combinationally, forced to zero while empty.
    always_comb begin
      if (empty_s) begin
        rd_data_s = {DATA_W{1'b0}};
      end else begin
        rd_data_s = mem_r[rd_ptr_r];
      end
    end
  end else begin : g_reg
    logic [DATA_W-1:0] rd_data_r;

    // Registered read port holds its value across flush and idle cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_data_r <= {DATA_W{1'b0}};
      end else if (rd_acc_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end

    assign rd_data_s = rd_data_r;
  end

  assign full_o         = full_s;
  assign empty_o        = empty_s;
  assign almost_full_o  = (level_r >= AF_L);
  assign almost_empty_o = (level_r <= AE_L);
  assign overflow_o     = overflow_r;
  assign underflow_o    = underflow_r;
  assign level_o        = level_r;
  assign rd_data_o      = rd_data_s;

endmodule
